ufm_flash_ctrl: RTL

//  Command sequencer for the ULA_UFM on-chip flash IP (MAX 10 UFM). Accepts single-word

---
 rtl/ufm_flash_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ufm_flash_ctrl.sv
// Command sequencer for the MAX 10 UFM on-chip flash: single-word read, write and
// sector erase, wrapped in unprotect / status-poll / re-protect CSR sequences.
module ufm_flash_ctrl #(
    parameter logic [4:0]  WP_DEFAULT = 5'b11111,
    parameter int unsigned POLL_LIMIT = 1048575,
    parameter int unsigned RD_LIMIT   = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [12:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [12:0] avmm_data_addr,
    output logic        avmm_data_read,
    output logic        avmm_data_write,
    output logic [31:0] avmm_data_writedata,
    output logic [1:0]  avmm_data_burstcount,
    input  logic [31:0] avmm_data_readdata,
    input  logic        avmm_data_waitrequest,
    input  logic        avmm_data_readdatavalid,
    output logic        avmm_csr_addr,
    output logic        avmm_csr_read,
    output logic        avmm_csr_write,
    output logic [31:0] avmm_csr_writedata,
    input  logic [31:0] avmm_csr_readdata
);

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_WAIT, UNPROT, ER_REQ, WR_REQ, POLL_RD, POLL_CHK, REPROT, RESP
    } state_t;

    localparam logic [19:0] POLL_LAST = 20'(POLL_LIMIT - 1);
    localparam logic [7:0]  RD_LAST   = 8'(RD_LIMIT - 1);

    state_t      state, state_d;
    logic        ready_q;
    logic [1:0]  op_q;
    logic [12:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [19:0] poll_cnt;
    logic [7:0]  rd_cnt;

    logic        accept;
    logic        sector_ok;
    logic        status_idle;
    logic [2:0]  sector;
    logic [4:0]  wp_open;
    logic        unused_status;

    function automatic logic [31:0] ctrl_word(input logic [4:0] wp, input logic [2:0] sec);
        return {4'hF, wp, sec, 20'hFFFFF};
    endfunction

    assign accept      = cmd_valid && cmd_ready;
    assign sector_ok   = (cmd_addr[2:0] != 3'd0) && (cmd_addr[2:0] <= 3'd5);
    assign status_idle = (avmm_csr_readdata[1:0] == 2'b00);
    // Writes only ever touch the two UFM sectors; bit 12 of the word address selects between them.
    assign sector      = (op_q == 2'b10) ? addr_q[2:0] : (addr_q[12] ? 3'd2 : 3'd1);
    assign wp_open     = WP_DEFAULT & ~(5'b00001 << (sector - 3'd1));
    assign unused_status = ^{avmm_csr_readdata[31:5], avmm_csr_readdata[2]};

    // ready_q holds cmd_ready low for the first cycle after reset release.
    assign cmd_ready            = ready_q && (state == IDLE);
    assign busy                 = (state != IDLE);
    assign rsp_valid            = (state == RESP);
    assign rsp_err              = (state == RESP) && err_q;
    assign rsp_data             = (state == RESP) ? rdata_q : 32'd0;
    assign avmm_data_addr       = addr_q;
    assign avmm_data_writedata  = wdata_q;
    assign avmm_data_burstcount = 2'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d            = state;
        avmm_data_read     = 1'b0;
        avmm_data_write    = 1'b0;
        avmm_csr_addr      = 1'b0;
        avmm_csr_read      = 1'b0;
        avmm_csr_write     = 1'b0;
        avmm_csr_writedata = 32'd0;
        case (state)
            IDLE: if (accept) begin
                case (cmd_op)
                    2'b00:   state_d = RD_REQ;
                    2'b01:   state_d = UNPROT;
                    2'b10:   state_d = sector_ok ? UNPROT : RESP;
                    default: state_d = RESP;
                endcase
            end
            RD_REQ: begin
                avmm_data_read = 1'b1;
                if (!avmm_data_waitrequest) state_d = RD_WAIT;
            end
            RD_WAIT: if (avmm_data_readdatavalid || rd_cnt >= RD_LAST) state_d = RESP;
            UNPROT: begin
                avmm_csr_write     = 1'b1;
                avmm_csr_addr      = 1'b1;
                avmm_csr_writedata = ctrl_word(wp_open, 3'b111);
                state_d            = (op_q == 2'b01) ? WR_REQ : ER_REQ;
            end
            ER_REQ: begin
                avmm_csr_write     = 1'b1;
                avmm_csr_addr      = 1'b1;
                avmm_csr_writedata = ctrl_word(wp_open, addr_q[2:0]);
                state_d            = POLL_RD;
            end
            WR_REQ: begin
                avmm_data_write = 1'b1;
                if (!avmm_data_waitrequest) state_d = POLL_RD;
            end
            POLL_RD: begin
                avmm_csr_read = 1'b1;
                state_d       = POLL_CHK;
            end
            POLL_CHK: begin
                if (status_idle || poll_cnt >= POLL_LAST) state_d = REPROT;
                else                                      state_d = POLL_RD;
            end
            REPROT: begin
                avmm_csr_write     = 1'b1;
                avmm_csr_addr      = 1'b1;
                avmm_csr_writedata = ctrl_word(WP_DEFAULT, 3'b111);
                state_d            = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q  <= 1'b0;
            op_q     <= 2'b00;
            addr_q   <= 13'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            poll_cnt <= 20'd0;
            rd_cnt   <= 8'd0;
        end else begin
            ready_q <= 1'b1;
            if (state == IDLE && accept) begin
                op_q     <= cmd_op;
                addr_q   <= cmd_addr;
                wdata_q  <= cmd_wdata;
                rdata_q  <= 32'd0;
                poll_cnt <= 20'd0;
                rd_cnt   <= 8'd0;
                err_q    <= (cmd_op == 2'b11) || (cmd_op == 2'b10 && !sector_ok);
            end
            if (state == RD_WAIT) begin
                if (avmm_data_readdatavalid)  rdata_q <= avmm_data_readdata;
                else if (rd_cnt >= RD_LAST)   err_q   <= 1'b1;
                else if (rd_cnt != 8'hFF)     rd_cnt  <= rd_cnt + 8'd1;
            end
            if (state == POLL_CHK) begin
                // A finished operation reports its own fail bit even on the last allowed poll.
                if (status_idle)
                    err_q <= (op_q == 2'b01) ? ~avmm_csr_readdata[3] : ~avmm_csr_readdata[4];
                else if (poll_cnt >= POLL_LAST) err_q <= 1'b1;
                else if (poll_cnt != 20'hFFFFF) poll_cnt <= poll_cnt + 20'd1;
            end
        end
    end

endmodule
